// File: rtl/stack_ctl.sv
// Sequencer and guard in front of a lifo stack: accepts one command at a time,
// rejects overflow/underflow, and expands compound ops into push/pop/swap strobes.
module stack_ctl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_s0,
  input  logic [WIDTH-1:0] i_s1,
  output logic [WIDTH-1:0] o_data,
  output logic             o_push,
  output logic             o_pop,
  output logic             o_swap,
  output logic [DW-1:0]    o_depth,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {IDLE, EXEC, NIP2, CLR} state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_DROP  = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_OVER  = 3'd5;
  localparam logic [2:0] OP_NIP   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic             swap_q, swap_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Strobes for the next cycle are decided one edge ahead so every output is a
  // flop; depth follows whatever strobe is currently on the wire.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = '0;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    swap_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    depth_d = depth_q;
    if (push_q) begin
      depth_d = depth_q + ONE;
    end else if (pop_q) begin
      depth_d = depth_q - ONE;
    end

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          op_d    = i_op;
          state_d = EXEC;
          done_d  = 1'b1;
          case (i_op)
            OP_PUSH: begin
              if (depth_q < DEPTH_MAX) begin
                push_d = 1'b1;
                data_d = i_data;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_DUP: begin
              if (depth_q != '0 && depth_q < DEPTH_MAX) begin
                push_d = 1'b1;
                data_d = i_s0;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_OVER: begin
              if (depth_q >= TWO && depth_q < DEPTH_MAX) begin
                push_d = 1'b1;
                data_d = i_s1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_DROP: begin
              if (depth_q != '0) begin
                pop_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_SWAP: begin
              if (depth_q >= TWO) begin
                swap_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_NIP: begin
              // Swap first, then the pop in NIP2 removes the old next-on-stack.
              if (depth_q >= TWO) begin
                swap_d = 1'b1;
                done_d = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              if (depth_q != '0) begin
                pop_d  = 1'b1;
                done_d = (depth_q == ONE);
              end
            end
            default: begin
            end
          endcase
        end
      end

      default: begin
        if (done_q) begin
          state_d = IDLE;
        end else if (state_q == EXEC && op_q == OP_NIP) begin
          state_d = NIP2;
          pop_d   = 1'b1;
          done_d  = 1'b1;
        end else if (depth_d != '0) begin
          state_d = CLR;
          pop_d   = 1'b1;
          done_d  = (depth_d == ONE);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      depth_q <= '0;
      data_q  <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      swap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      depth_q <= depth_d;
      data_q  <= data_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      swap_q  <= swap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_data  = data_q;
  assign o_push  = push_q;
  assign o_pop   = pop_q;
  assign o_swap  = swap_q;
  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_depth = depth_q;
  assign o_empty = (depth_q == '0);
  assign o_full  = (depth_q == DEPTH_MAX);

endmodule

// File: tb/tb_stack_ctl.sv
// Scoreboard bench for stack_ctl: a reference stack predicts every execute
// cycle's strobes, and a small lifo model feeds s0/s1 back from the strobes.
module tb_stack_ctl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 12;
  localparam int DW    = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_DROP  = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_OVER  = 3'd5;
  localparam logic [2:0] OP_NIP   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [2:0]       i_op = 3'd0;
  logic [WIDTH-1:0] i_data = '0;
  logic [WIDTH-1:0] i_s0;
  logic [WIDTH-1:0] i_s1;
  logic [WIDTH-1:0] o_data;
  logic             o_push, o_pop, o_swap;
  logic [DW-1:0]    o_depth;
  logic             o_empty, o_full, o_done, o_err;

  int checkCount = 0;
  int passCount  = 0;

  logic [12:0] sbQueue [$];
  logic [7:0]  refStack [$];

  logic [7:0]  lifoMem [0:31];
  logic [4:0]  lifoCnt;

  stack_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_data(i_data), .i_s0(i_s0), .i_s1(i_s1), .o_data(o_data),
    .o_push(o_push), .o_pop(o_pop), .o_swap(o_swap), .o_depth(o_depth),
    .o_empty(o_empty), .o_full(o_full), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Stand-in for the lifo instance, driven only by the DUT strobes.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lifoCnt <= 5'd0;
    end else if (o_push && lifoCnt < 5'd31) begin
      lifoMem[lifoCnt] <= o_data;
      lifoCnt <= lifoCnt + 5'd1;
    end else if (o_pop && lifoCnt != 5'd0) begin
      lifoCnt <= lifoCnt - 5'd1;
    end else if (o_swap && lifoCnt >= 5'd2) begin
      lifoMem[lifoCnt - 5'd1] <= lifoMem[lifoCnt - 5'd2];
      lifoMem[lifoCnt - 5'd2] <= lifoMem[lifoCnt - 5'd1];
    end
  end

  always_comb begin
    i_s0 = (lifoCnt >= 5'd1) ? lifoMem[lifoCnt - 5'd1] : 8'h00;
    i_s1 = (lifoCnt >= 5'd2) ? lifoMem[lifoCnt - 5'd2] : 8'h00;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [12:0] pk(input bit push, input bit pop, input bit swap,
                                     input bit done, input bit err, input logic [7:0] data);
    return {err, done, swap, pop, push, data};
  endfunction

  // Every execute cycle raises at least one of push/pop/swap/done, so any
  // cycle with activity must match the next predicted entry.
  always @(negedge i_clk) begin
    if (i_rst_n && (o_push || o_pop || o_swap || o_done)) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_cycle", {19'd0, o_err, o_done, o_swap, o_pop, o_push, o_data}, 32'd0);
      end else begin
        checkOutput("exec_cycle", {19'd0, o_err, o_done, o_swap, o_pop, o_push, o_data},
                    {19'd0, sbQueue.pop_front()});
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data, input bit waitDone);
    int d;
    int n;
    bit legal;
    bit seen;
    logic [7:0] s0, s1;
    d  = refStack.size();
    s0 = (d > 0) ? refStack[d-1] : 8'h00;
    s1 = (d > 1) ? refStack[d-2] : 8'h00;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    legal = 1'b1;
    case (op)
      OP_PUSH:  legal = (d < DEPTH);
      OP_DUP:   legal = (d >= 1 && d < DEPTH);
      OP_OVER:  legal = (d >= 2 && d < DEPTH);
      OP_DROP:  legal = (d >= 1);
      OP_SWAP:  legal = (d >= 2);
      OP_NIP:   legal = (d >= 2);
      default:  legal = 1'b1;
    endcase
    if (!legal) begin
      sbQueue.push_back(pk(0, 0, 0, 1, 1, 8'h00));
    end else begin
      case (op)
        OP_PUSH: sbQueue.push_back(pk(1, 0, 0, 1, 0, data));
        OP_DUP:  sbQueue.push_back(pk(1, 0, 0, 1, 0, s0));
        OP_OVER: sbQueue.push_back(pk(1, 0, 0, 1, 0, s1));
        OP_DROP: sbQueue.push_back(pk(0, 1, 0, 1, 0, 8'h00));
        OP_SWAP: sbQueue.push_back(pk(0, 0, 1, 1, 0, 8'h00));
        OP_NIP: begin
          sbQueue.push_back(pk(0, 0, 1, 0, 0, 8'h00));
          sbQueue.push_back(pk(0, 1, 0, 1, 0, 8'h00));
        end
        OP_CLEAR: begin
          if (d == 0) sbQueue.push_back(pk(0, 0, 0, 1, 0, 8'h00));
          for (int i = 0; i < d; i++) sbQueue.push_back(pk(0, 1, 0, (i == d-1), 0, 8'h00));
        end
        default: sbQueue.push_back(pk(0, 0, 0, 1, 0, 8'h00));
      endcase
    end
    i_valid = 1'b1;
    i_op    = op;
    i_data  = data;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_op    = OP_NOP;
    i_data  = 8'h00;
    if (waitDone) begin
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
        @(negedge i_clk);
        if (o_done) seen = 1'b1;
        n++;
      end
      if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
      if (legal) begin
        case (op)
          OP_PUSH:  refStack.push_back(data);
          OP_DUP:   refStack.push_back(s0);
          OP_OVER:  refStack.push_back(s1);
          OP_DROP:  void'(refStack.pop_back());
          OP_SWAP: begin
            refStack[d-1] = s1;
            refStack[d-2] = s0;
          end
          OP_NIP: begin
            refStack[d-2] = s0;
            void'(refStack.pop_back());
          end
          OP_CLEAR: refStack.delete();
          default: begin
          end
        endcase
      end
      @(negedge i_clk);
      checkOutput("sb_drain", sbQueue.size(), 32'd0);
      checkOutput("depth", {28'd0, o_depth}, refStack.size());
      checkOutput("empty_full", {30'd0, o_empty, o_full},
                  {30'd0, (refStack.size() == 0), (refStack.size() == DEPTH)});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    $display("[TB] stack_ctl bench starting");
    repeat (3) @(negedge i_clk);
    checkOutput("rst_outputs", {19'd0, o_err, o_done, o_swap, o_pop, o_push, o_data}, 32'd0);
    checkOutput("rst_status", {25'd0, o_ready, o_empty, o_full, o_depth}, {25'd0, 1'b1, 1'b1, 1'b0, 4'd0});
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Basic data path: PUSH, PUSH, DUP copies s0, OVER copies s1.
    applyStimulus(OP_PUSH, 8'h11, 1'b1);
    applyStimulus(OP_PUSH, 8'h22, 1'b1);
    applyStimulus(OP_DUP, 8'h00, 1'b1);
    applyStimulus(OP_OVER, 8'h00, 1'b1);
    checkOutput("over_top", i_s0, 32'h22);
    applyStimulus(OP_NOP, 8'h00, 1'b1);
    applyStimulus(OP_SWAP, 8'h00, 1'b1);
    applyStimulus(OP_CLEAR, 8'h00, 1'b1);
    applyStimulus(OP_CLEAR, 8'h00, 1'b1);

    // Fill to the limit, then overflow.
    for (int i = 0; i < DEPTH; i++) applyStimulus(OP_PUSH, 8'($urandom_range(1, 255)), 1'b1);
    checkOutput("full_flag", o_full, 32'd1);
    applyStimulus(OP_PUSH, 8'hAA, 1'b1);
    applyStimulus(OP_DUP, 8'h00, 1'b1);
    applyStimulus(OP_CLEAR, 8'h00, 1'b1);

    // Underflow guards.
    applyStimulus(OP_DROP, 8'h00, 1'b1);
    applyStimulus(OP_PUSH, 8'h5A, 1'b1);
    applyStimulus(OP_SWAP, 8'h00, 1'b1);
    applyStimulus(OP_NIP, 8'h00, 1'b1);
    applyStimulus(OP_OVER, 8'h00, 1'b1);
    checkOutput("guard_depth", {28'd0, o_depth}, 32'd1);
    applyStimulus(OP_DROP, 8'h00, 1'b1);

    // NIP on 0x55, 0x44, 0x33 (top).
    applyStimulus(OP_PUSH, 8'h55, 1'b1);
    applyStimulus(OP_PUSH, 8'h44, 1'b1);
    applyStimulus(OP_PUSH, 8'h33, 1'b1);
    applyStimulus(OP_NIP, 8'h00, 1'b1);
    checkOutput("nip_s0", i_s0, 32'h33);
    checkOutput("nip_s1", i_s1, 32'h55);

    // CLEAR from depth 5.
    applyStimulus(OP_PUSH, 8'h01, 1'b1);
    applyStimulus(OP_PUSH, 8'h02, 1'b1);
    applyStimulus(OP_PUSH, 8'h03, 1'b1);
    applyStimulus(OP_CLEAR, 8'h00, 1'b1);

    // Reset in the middle of a CLEAR.
    for (int i = 0; i < 6; i++) applyStimulus(OP_PUSH, 8'(i + 16), 1'b1);
    applyStimulus(OP_CLEAR, 8'h00, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    sbQueue.delete();
    refStack.delete();
    checkOutput("midrst_outputs", {19'd0, o_err, o_done, o_swap, o_pop, o_push, o_data}, 32'd0);
    checkOutput("midrst_status", {25'd0, o_ready, o_empty, o_full, o_depth}, {25'd0, 1'b1, 1'b1, 1'b0, 4'd0});
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checkOutput("post_rst_status", {25'd0, o_ready, o_empty, o_full, o_depth}, {25'd0, 1'b1, 1'b1, 1'b0, 4'd0});
    applyStimulus(OP_PUSH, 8'h77, 1'b1);
    applyStimulus(OP_DROP, 8'h00, 1'b1);
    repeat (3) @(negedge i_clk);
    checkOutput("final_drain", sbQueue.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
